// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - constants and elaboration-time pattern helpers for seq_detector
//
// Purpose: shared widths and constant functions used to build the
//   per-state transition table of seq_detector during elaboration.
//   A pattern is held right-aligned in a MAX_W-bit vector; bit w-1 is
//   the first bit received and bit 0 is the last.
// Ports: none (package).

package seq_detector_pkg;

  localparam int MAX_W  = 16;
  localparam int MAX_SW = $clog2(MAX_W + 1);

  // Widest state any instance can need; instances size their own state
  // with state_width(W).
  typedef logic [MAX_SW-1:0] state_max_t;

  function automatic int state_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Length of the longest proper prefix of the pattern that is also a suffix.
  function automatic int border_len(input logic [MAX_W-1:0] pattern, input int w);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < MAX_W; k++) begin
      if (k < w) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
          if (i < k) begin
            if (pattern[w-1-i] != pattern[k-1-i]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest pattern prefix that is a suffix of (first s pattern bits ++ x).
  // May return w, meaning the bit completes a full match.
  function automatic int next_state(input logic [MAX_W-1:0] pattern, input int w,
                                    input int s, input logic x);
    int   best;
    int   j;
    logic ok;
    logic tbit;
    best = 0;
    for (int k = 1; k <= MAX_W; k++) begin
      if (k <= w && k <= s + 1) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
          if (i < k) begin
            j = s + 1 - k + i;
            if (j == s) tbit = x;
            else        tbit = pattern[w-1-j];
            if (tbit != pattern[w-1-i]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // State a non-overlapping detector restarts from: the full-match state
  // behaves like the idle state.
  function automatic int source_state(input int w, input int s, input int overlap);
    if (s >= w && overlap == 0) return 0;
    return s;
  endfunction

  // Registered successor state, folding in the Mealy/Moore and overlap rules.
  function automatic int step_state(input logic [MAX_W-1:0] pattern, input int w,
                                    input int s, input logic x,
                                    input int moore, input int overlap);
    int n;
    n = next_state(pattern, w, source_state(w, s, overlap), x);
    // Mealy never parks in the full-match state; it jumps straight to the
    // state the next search continues from.
    if (n == w && moore == 0) begin
      if (overlap != 0) n = border_len(pattern, w);
      else              n = 0;
    end
    return n;
  endfunction

  function automatic bit is_hit(input logic [MAX_W-1:0] pattern, input int w,
                                input int s, input logic x, input int overlap);
    return next_state(pattern, w, source_state(w, s, overlap), x) == w;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter for seq_detector
//
// Purpose: counts full-match events, sticks at all-ones, cleared by reset.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   inc_i    in   full match sampled on this edge
//   count_o  out  CNT_W-bit saturating count

module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - parametrised serial bit-pattern detector
//
// Purpose: detects PATTERN (W bits, PATTERN[W-1] received first) on the
//   serial input x, sampled on rising clk while en is high. MOORE selects a
//   combinational (0) or registered (1) match output; OVERLAP selects whether
//   the tail of a match may begin the next one.
//   The transition table is a set of elaboration-time constants.
// Optional feature: define SEQ_DETECTOR_COUNT_EN to add the match_count port
//   and its saturating counter.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   en           in   sample enable for x
//   x            in   serial data bit
//   q            out  match indication
//   match_count  out  CNT_W-bit saturating match count (SEQ_DETECTOR_COUNT_EN)

module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] PATTERN = 4'b1011,
  parameter int           MOORE   = 0,
  parameter int           OVERLAP = 1,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
`ifdef SEQ_DETECTOR_COUNT_EN
  output logic [CNT_W-1:0] match_count,
`endif
  output logic             q
);

  localparam int               SW      = state_width(W);
  localparam int               NS      = 1 << SW;
  localparam logic [MAX_W-1:0] PAT_EXT = MAX_W'(PATTERN);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          hit;

  logic [NS-1:0][SW-1:0] nxt0_tab;
  logic [NS-1:0][SW-1:0] nxt1_tab;
  logic [NS-1:0]         hit0_tab;
  logic [NS-1:0]         hit1_tab;

  // One table row per encodable state; rows for unreachable encodings
  // fall back to the idle state.
  for (genvar g = 0; g < NS; g++) begin : g_tab
    if ((g < W) || (MOORE != 0 && g == W)) begin : g_live
      localparam logic [SW-1:0] N0 = SW'(step_state(PAT_EXT, W, g, 1'b0, MOORE, OVERLAP));
      localparam logic [SW-1:0] N1 = SW'(step_state(PAT_EXT, W, g, 1'b1, MOORE, OVERLAP));
      localparam bit            H0 = is_hit(PAT_EXT, W, g, 1'b0, OVERLAP);
      localparam bit            H1 = is_hit(PAT_EXT, W, g, 1'b1, OVERLAP);
      assign nxt0_tab[g] = N0;
      assign nxt1_tab[g] = N1;
      assign hit0_tab[g] = H0;
      assign hit1_tab[g] = H1;
    end else begin : g_dead
      assign nxt0_tab[g] = '0;
      assign nxt1_tab[g] = '0;
      assign hit0_tab[g] = 1'b0;
      assign hit1_tab[g] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  // hit is the full-match condition for the bit being sampled this cycle.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (en) begin
      state_d = x ? nxt1_tab[state_q] : nxt0_tab[state_q];
      hit     = x ? hit1_tab[state_q] : hit0_tab[state_q];
    end
  end

  always_comb begin
    q = 1'b0;
    if (MOORE != 0) q = (state_q == SW'(W));
    else            q = hit;
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (hit),
    .count_o (match_count)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - self-checking bench for seq_detector

module tb_seq_detector;

  localparam int          NI     = 6;
  localparam int          CW [NI] = '{4, 4, 4, 4, 6, 6};
  localparam logic [15:0] CP [NI] = '{16'h000b, 16'h000b, 16'h000b, 16'h000b, 16'h0036, 16'h0036};
  localparam int          CM [NI] = '{0, 1, 0, 1, 0, 1};
  localparam int          CO [NI] = '{1, 1, 0, 0, 1, 0};

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          en    = 1'b0;
  logic          x     = 1'b0;
  logic [NI-1:0] qv;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
`ifdef SEQ_DETECTOR_COUNT_EN
    logic [7:0] cnt;
`endif
    seq_detector #(
      .W       (CW[k]),
      .PATTERN (CP[k][CW[k]-1:0]),
      .MOORE   (CM[k]),
      .OVERLAP (CO[k]),
      .CNT_W   (8)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .x           (x),
`ifdef SEQ_DETECTOR_COUNT_EN
      .match_count (cnt),
`endif
      .q           (qv[k])
    );
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [1:0] cnt2;
  logic       q_cnt2;
  seq_detector #(
    .W(4), .PATTERN(4'b1011), .MOORE(0), .OVERLAP(1), .CNT_W(2)
  ) u_cnt2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .match_count(cnt2), .q(q_cnt2)
  );
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: raw history of sampled bits per instance, newest in bit 0.
  logic [15:0] hist [NI];
  int          hlen [NI];
  bit          mo_flag [NI];
  bit          prev_ml;
  int          cnt_model;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [15:0] wmask(input int w);
    return 16'((32'h1 << w) - 1);
  endfunction

  function automatic bit ref_match(input int k, input logic b);
    logic [15:0] h;
    h = {hist[k][14:0], b};
    return (hlen[k] + 1 >= CW[k]) && (((h ^ CP[k]) & wmask(CW[k])) == 16'h0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      hist[k]    = '0;
      hlen[k]    = 0;
      mo_flag[k] = 1'b0;
    end
    prev_ml   = 1'b0;
    cnt_model = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b1;
    x     = 1'b1;
    #2;
    check("reset q", int'(qv), 0);
`ifdef SEQ_DETECTOR_COUNT_EN
    check("reset count", int'(g_dut[0].cnt), 0);
    check("reset count2", int'(cnt2), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    en    = 1'b0;
    x     = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, check every instance against the model, then advance.
  task automatic step(input logic e, input logic b, input string tag);
    bit m [NI];
    en = e;
    x  = b;
    #1;
    for (int k = 0; k < NI; k++) begin
      m[k] = e && ref_match(k, b);
      check($sformatf("%s q[%0d]", tag, k), int'(qv[k]), CM[k] != 0 ? int'(mo_flag[k]) : int'(m[k]));
    end
    check($sformatf("%s moore offset", tag), int'(qv[1]), int'(prev_ml));
`ifdef SEQ_DETECTOR_COUNT_EN
    check($sformatf("%s count", tag), int'(g_dut[0].cnt), cnt_model);
`endif
    if (e) begin
      for (int k = 0; k < NI; k++) begin
        hist[k] = {hist[k][14:0], b};
        hlen[k] = (hlen[k] < 16) ? hlen[k] + 1 : 16;
        if (m[k] && CO[k] == 0) hlen[k] = 0;
        mo_flag[k] = m[k];
      end
      prev_ml = qv[0];
      if (m[0] && cnt_model < 255) cnt_model++;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit         rst;
    bit         e;
    bit         b;
    logic [3:0] expq;   // {OL0 Moore, OL0 Mealy, OL1 Moore, OL1 Mealy}
  } vec_t;

  vec_t tbl [25];

  initial begin
    tbl = '{
      '{1'b0, 1'b1, 1'b1, 4'b0000}, '{1'b0, 1'b1, 1'b0, 4'b0000},
      '{1'b0, 1'b1, 1'b1, 4'b0000}, '{1'b0, 1'b1, 1'b1, 4'b0101},
      '{1'b0, 1'b1, 1'b0, 4'b1010}, '{1'b0, 1'b1, 1'b1, 4'b0000},
      '{1'b0, 1'b1, 1'b1, 4'b0001}, '{1'b0, 1'b0, 1'b0, 4'b0010},
      '{1'b0, 1'b0, 1'b1, 4'b0010}, '{1'b1, 1'b0, 1'b0, 4'b0000},
      '{1'b0, 1'b1, 1'b1, 4'b0000}, '{1'b0, 1'b1, 1'b0, 4'b0000},
      '{1'b0, 1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b0, 1'b1, 4'b0000},
      '{1'b0, 1'b0, 1'b0, 4'b0000}, '{1'b0, 1'b1, 1'b1, 4'b0000},
      '{1'b0, 1'b0, 1'b1, 4'b0000}, '{1'b0, 1'b1, 1'b1, 4'b0101},
      '{1'b0, 1'b0, 1'b0, 4'b1010}, '{1'b0, 1'b0, 1'b1, 4'b1010},
      '{1'b0, 1'b0, 1'b0, 4'b1010}, '{1'b0, 1'b1, 1'b0, 4'b1010},
      '{1'b0, 1'b1, 1'b1, 4'b0000}, '{1'b0, 1'b1, 1'b1, 4'b0001},
      '{1'b0, 1'b0, 1'b0, 4'b0010}
    };

    model_reset();
    #1;
    do_reset();

    // Directed streams with hand-derived expectations.
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        en = tbl[i].e;
        x  = tbl[i].b;
        #1;
        check($sformatf("table row %0d", i), int'(qv[3:0]), int'(tbl[i].expq));
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a partial match, away from any clock edge.
    do_reset();
    step(1'b1, 1'b1, "rst_mid a");
    step(1'b1, 1'b0, "rst_mid b");
    step(1'b1, 1'b1, "rst_mid c");
    en = 1'b1;
    x  = 1'b1;
    #1;
    check("pre-reset mealy q", int'(qv[0]), 1);
    reset = 1'b1;
    #1;
    check("async reset q", int'(qv), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b1, "post_rst 1");
    step(1'b1, 1'b1, "post_rst 2");
    step(1'b1, 1'b1, "post_rst 3");
    step(1'b1, 1'b0, "post_rst 4");
    step(1'b1, 1'b1, "post_rst 5");
    en = 1'b1;
    x  = 1'b1;
    #1;
    check("post-reset full match", int'(qv[0]), 1);
    step(1'b1, 1'b1, "post_rst 6");

`ifdef SEQ_DETECTOR_COUNT_EN
    // Five overlapping matches into a 2-bit counter.
    begin
      logic [15:0] bits;
      do_reset();
      bits = 16'b1011011011011011;
      for (int i = 0; i < 16; i++) begin
        step(1'b1, bits[15-i], "count");
        if (i >= 3 && (i % 3) == 0)
          check($sformatf("sat count after bit %0d", i + 1), int'(cnt2), ((i - 3) / 3 + 1 > 3) ? 3 : (i - 3) / 3 + 1);
      end
    end
`endif

    // Random stream against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
